// File: rtl/sum_fifo_if.sv
// sum_fifo_if: producer/consumer bundle for sum_fifo.
// master drives beats and pops, slave is the FIFO.
interface sum_fifo_if #(
  parameter int N     = 32,
  parameter int CH    = 2,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [CH*N-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [AW:0]     level;
  logic            ovf;
  logic            clr_ovf;

  modport master (
    output in_data, in_valid, out_ready, clr_ovf,
    input  in_ready, out_data, out_valid, level, ovf
  );

  modport slave (
    input  in_data, in_valid, out_ready, clr_ovf,
    output in_ready, out_data, out_valid, level, ovf
  );
endinterface

// File: rtl/sum_fifo.sv
// sum_fifo: sums CH channels per beat into a first-word-fall-through FIFO.
// Define SUM_FIFO_SAT_EN to saturate overflowing sums instead of wrapping.
module sum_fifo #(
  parameter int N     = 32,
  parameter int CH    = 2,
  parameter int DEPTH = 16
) (
  input logic       clk,
  input logic       rst,
  sum_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = N + $clog2(CH);

  logic [SW-1:0] sum_c;
  logic          big_c;
  logic [N-1:0]  fit_c;
  logic [AW+1:0] occ_c;
  logic          rdy_c;
  logic          acc_c;
  logic          push_c;
  logic          pop_c;
  logic [AW-1:0] rp_nx;

  logic [N-1:0]  mem_q [DEPTH];
  logic [N-1:0]  stg_q, stg_d;
  logic [N-1:0]  head_q, head_d;
  logic          stv_q, stv_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   lvl_q, lvl_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < CH; k++)
      sum_c = sum_c + SW'(bus.in_data[k*N +: N]);
  end

  assign big_c = |sum_c[SW-1:N];

`ifdef SUM_FIFO_SAT_EN
  assign fit_c = big_c ? '1 : sum_c[N-1:0];
`else
  assign fit_c = sum_c[N-1:0];
`endif

  // The stage always has a slot reserved, so it never stalls.
  assign occ_c  = {1'b0, lvl_q} + (AW+2)'(stv_q);
  assign rdy_c  = !rst && (occ_c < (AW+2)'(DEPTH));
  assign acc_c  = bus.in_valid && rdy_c;
  assign push_c = stv_q;
  assign pop_c  = bus.out_ready && (lvl_q != '0);
  assign rp_nx  = rp_q + AW'(1);

  always_comb begin
    stv_d  = acc_c;
    stg_d  = acc_c ? fit_c : stg_q;
    ovf_d  = (acc_c && big_c) || (ovf_q && !bus.clr_ovf);
    wp_d   = push_c ? wp_q + AW'(1) : wp_q;
    rp_d   = pop_c ? rp_nx : rp_q;
    lvl_d  = lvl_q;
    head_d = head_q;
    unique case ({push_c, pop_c})
      2'b10:   lvl_d = lvl_q + (AW+1)'(1);
      2'b01:   lvl_d = lvl_q - (AW+1)'(1);
      default: ;
    endcase
    // With one entry left, its successor is still in the stage.
    unique case (1'b1)
      push_c && (lvl_q == '0):
        head_d = stg_q;
      pop_c && (lvl_q > (AW+1)'(1)):
        head_d = mem_q[rp_nx];
      pop_c && push_c && (lvl_q == (AW+1)'(1)):
        head_d = stg_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stv_q  <= 1'b0;
      stg_q  <= '0;
      head_q <= '0;
      ovf_q  <= 1'b0;
      lvl_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
    end else begin
      stv_q  <= stv_d;
      stg_q  <= stg_d;
      head_q <= head_d;
      ovf_q  <= ovf_d;
      lvl_q  <= lvl_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c)
      mem_q[wp_q] <= stg_q;
  end

  assign bus.in_ready  = rdy_c;
  assign bus.out_valid = (lvl_q != '0);
  assign bus.out_data  = head_q;
  assign bus.level     = lvl_q;
  assign bus.ovf       = ovf_q;
endmodule
